// File: rtl/st_m_timed.sv
// st_m_timed: four-state Moore command controller (S0..S3) with input
// qualification, a sticky error state, per-state dwell timeout back to S0
// and a saturating count of state changes.
//
// Handshake: there is no back-pressure. in_data is consumed on every rising
// edge where in_valid=1 and the controller is not in ERR; in any other cycle
// in_data is don't-care. While in ERR, in_valid is ignored and only
// err_clear moves the controller back to S0.
module st_m_timed #(
   parameter int                   STATE_LEN = 3,
   parameter int                   INP_LEN   = 3,
   parameter int                   OUT_LEN   = 2,
   parameter logic [STATE_LEN-1:0] S0        = 3'b000,
   parameter logic [STATE_LEN-1:0] S1        = 3'b010,
   parameter logic [STATE_LEN-1:0] S2        = 3'b100,
   parameter logic [STATE_LEN-1:0] S3        = 3'b001,
   parameter logic [STATE_LEN-1:0] S_ERR     = 3'b111,
   parameter logic [INP_LEN-1:0]   X0        = 3'b001,
   parameter logic [INP_LEN-1:0]   X1        = 3'b010,
   parameter logic [INP_LEN-1:0]   X2        = 3'b100,
   parameter logic [OUT_LEN-1:0]   Y0        = 2'b01,
   parameter logic [OUT_LEN-1:0]   Y1        = 2'b10,
   parameter logic [OUT_LEN-1:0]   Y2        = 2'b11,
   parameter logic [OUT_LEN-1:0]   Y_ERR     = 2'b00,
   parameter int                   TIMEOUT   = 16,
   parameter int                   CNT_W     = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [INP_LEN-1:0]   in_data,
   input  logic                 err_clear,
   output logic [OUT_LEN-1:0]   out_data,
   output logic [STATE_LEN-1:0] state,
   output logic                 err,
   output logic                 timeout_pulse,
   output logic [CNT_W-1:0]     trans_cnt
);

   typedef enum logic [STATE_LEN-1:0] {
      ST_S0  = S0,
      ST_S1  = S1,
      ST_S2  = S2,
      ST_S3  = S3,
      ST_ERR = S_ERR
   } state_t;

   // Dwell never needs to exceed TIMEOUT-1: the timeout fires at that value.
   localparam int DW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [DW-1:0]    DWELL_MAX = (TIMEOUT > 0) ? DW'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_q;
   state_t           state_d;
   logic [DW-1:0]    dwell_q;
   logic             accepted;
   logic             legal;
   logic             in_busy_state;
   logic             timeout_hit;
   logic             changing;

   assign accepted      = in_valid && (state_q != ST_ERR);
   assign legal         = (in_data == X0) || (in_data == X1) || (in_data == X2);
   assign in_busy_state = (state_q == ST_S1) || (state_q == ST_S2) || (state_q == ST_S3);
   assign timeout_hit   = (TIMEOUT != 0) && in_busy_state && !in_valid && (dwell_q == DWELL_MAX);
   assign changing      = (state_d != state_q);

   // Next-state logic: accepted input first, then timeout, else hold.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_S0, ST_S1, ST_S2, ST_S3: begin
            if (accepted) begin
               if (!legal) begin
                  state_d = ST_ERR;
               end else begin
                  case (state_q)
                     ST_S0:   state_d = (in_data == X1) ? ST_S1 : (in_data == X2) ? ST_S2 : ST_S0;
                     ST_S1:   state_d = (in_data == X1) ? ST_S2 : (in_data == X2) ? ST_S3 : ST_S0;
                     ST_S2:   state_d = (in_data == X1) ? ST_S3 : ST_S0;
                     ST_S3:   state_d = (in_data == X2) ? ST_S1 : ST_S0;
                     default: state_d = ST_S0;
                  endcase
               end
            end else if (timeout_hit) begin
               state_d = ST_S0;
            end
         end
         ST_ERR:  state_d = err_clear ? ST_S0 : ST_ERR;
         default: state_d = ST_S0;
      endcase
   end

   // State register, dwell counter, timeout pulse and transition counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_S0;
         dwell_q       <= '0;
         timeout_pulse <= 1'b0;
         trans_cnt     <= '0;
      end else begin
         state_q       <= state_d;
         timeout_pulse <= timeout_hit;
         if ((TIMEOUT == 0) || accepted || changing || !in_busy_state) begin
            dwell_q <= '0;
         end else begin
            dwell_q <= dwell_q + DW'(1);
         end
         if (changing && (trans_cnt != CNT_MAX)) begin
            trans_cnt <= trans_cnt + CNT_W'(1);
         end
      end
   end

   // Moore output decode from the state register.
   always_comb begin
      out_data = Y0;
      case (state_q)
         ST_S0:   out_data = Y0;
         ST_S1:   out_data = Y1;
         ST_S2:   out_data = Y1;
         ST_S3:   out_data = Y2;
         ST_ERR:  out_data = Y_ERR;
         default: out_data = Y0;
      endcase
   end

   assign state = state_q;
   assign err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_st_m_timed.sv
// Directed testbench for st_m_timed. A second instance with CNT_W=3 shares
// all inputs so counter saturation can be observed at a small width.
module tb_st_m_timed;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_data = 3'b000;
   logic       err_clear = 1'b0;

   logic [1:0] out_data;
   logic [2:0] state;
   logic       err;
   logic       timeout_pulse;
   logic [7:0] trans_cnt;

   logic [1:0] out_data3;
   logic [2:0] state3;
   logic       err3;
   logic       timeout_pulse3;
   logic [2:0] trans_cnt3;

   int checks = 0;
   int failures = 0;

   localparam logic [2:0] P_S0 = 3'b000, P_S1 = 3'b010, P_S2 = 3'b100, P_S3 = 3'b001, P_ERR = 3'b111;
   localparam logic [2:0] P_X0 = 3'b001, P_X1 = 3'b010, P_X2 = 3'b100;

   // Clock generation: 10 ns period.
   always #5 clock = ~clock;

   st_m_timed #(.TIMEOUT(16), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .err_clear(err_clear), .out_data(out_data), .state(state), .err(err),
      .timeout_pulse(timeout_pulse), .trans_cnt(trans_cnt)
   );

   st_m_timed #(.TIMEOUT(16), .CNT_W(3)) dut3 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .err_clear(err_clear), .out_data(out_data3), .state(state3), .err(err3),
      .timeout_pulse(timeout_pulse3), .trans_cnt(trans_cnt3)
   );

   // One clock edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] d, input logic clr);
      in_valid  = v;
      in_data   = d;
      err_clear = clr;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = 3'b000; err_clear = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state !== P_S0) begin failures++; $display("FAIL reset_state got=%b exp=%b", state, P_S0); end
      checks++; if (out_data !== 2'b01) begin failures++; $display("FAIL reset_out got=%b exp=01", out_data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (timeout_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", timeout_pulse); end
      checks++; if (trans_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", trans_cnt); end
   endtask

   task automatic test_sequence();
      logic [2:0] ins [5];
      logic [2:0] exp_st [5];
      logic [1:0] exp_out [5];
      ins     = '{P_X1, P_X1, P_X1, P_X2, P_X0};
      exp_st  = '{P_S1, P_S2, P_S3, P_S1, P_S0};
      exp_out = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b01};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, ins[i], 1'b0);
         checks++; if (state !== exp_st[i]) begin failures++; $display("FAIL seq_state[%0d] got=%b exp=%b", i, state, exp_st[i]); end
         checks++; if (out_data !== exp_out[i]) begin failures++; $display("FAIL seq_out[%0d] got=%b exp=%b", i, out_data, exp_out[i]); end
      end
      checks++; if (trans_cnt !== 8'd5) begin failures++; $display("FAIL seq_cnt got=%0d exp=5", trans_cnt); end
      // Self-loop S0 on X0 is not a state change.
      drive(1'b1, P_X0, 1'b0);
      checks++; if (state !== P_S0) begin failures++; $display("FAIL selfloop_state got=%b exp=%b", state, P_S0); end
      checks++; if (trans_cnt !== 8'd5) begin failures++; $display("FAIL selfloop_cnt got=%0d exp=5", trans_cnt); end
   endtask

   task automatic test_err();
      do_reset();
      drive(1'b1, P_X1, 1'b0);
      drive(1'b1, P_X1, 1'b0);
      checks++; if (state !== P_S2) begin failures++; $display("FAIL err_pre_state got=%b exp=%b", state, P_S2); end
      drive(1'b1, 3'b011, 1'b0);
      checks++; if (state !== P_ERR) begin failures++; $display("FAIL err_state got=%b exp=%b", state, P_ERR); end
      checks++; if (out_data !== 2'b00) begin failures++; $display("FAIL err_out got=%b exp=00", out_data); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", err); end
      checks++; if (trans_cnt !== 8'd3) begin failures++; $display("FAIL err_cnt got=%0d exp=3", trans_cnt); end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, P_X1, 1'b0);
         checks++; if (state !== P_ERR) begin failures++; $display("FAIL err_sticky[%0d] got=%b exp=%b", i, state, P_ERR); end
      end
      drive(1'b0, P_X1, 1'b1);
      checks++; if (state !== P_S0) begin failures++; $display("FAIL err_clear_state got=%b exp=%b", state, P_S0); end
      checks++; if (out_data !== 2'b01) begin failures++; $display("FAIL err_clear_out got=%b exp=01", out_data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear_flag got=%b exp=0", err); end
      checks++; if (trans_cnt !== 8'd4) begin failures++; $display("FAIL err_clear_cnt got=%0d exp=4", trans_cnt); end
      // err_clear outside ERR has no effect.
      drive(1'b0, P_X0, 1'b1);
      checks++; if (state !== P_S0) begin failures++; $display("FAIL clr_idle_state got=%b exp=%b", state, P_S0); end
   endtask

   task automatic test_timeout();
      do_reset();
      drive(1'b1, P_X1, 1'b0);
      checks++; if (state !== P_S1) begin failures++; $display("FAIL to_entry got=%b exp=%b", state, P_S1); end
      for (int k = 1; k <= 15; k++) begin
         drive(1'b0, P_X2, 1'b0);
         checks++; if (state !== P_S1 || timeout_pulse !== 1'b0) begin
            failures++; $display("FAIL to_hold[%0d] state=%b pulse=%b exp state=%b pulse=0", k, state, timeout_pulse, P_S1);
         end
      end
      drive(1'b0, P_X2, 1'b0);
      checks++; if (state !== P_S0) begin failures++; $display("FAIL to_fire_state got=%b exp=%b", state, P_S0); end
      checks++; if (timeout_pulse !== 1'b1) begin failures++; $display("FAIL to_fire_pulse got=%b exp=1", timeout_pulse); end
      checks++; if (trans_cnt !== 8'd2) begin failures++; $display("FAIL to_cnt got=%0d exp=2", trans_cnt); end
      drive(1'b0, P_X2, 1'b0);
      checks++; if (timeout_pulse !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout_pulse); end
      checks++; if (state !== P_S0) begin failures++; $display("FAIL to_after got=%b exp=%b", state, P_S0); end
   endtask

   task automatic test_timeout_race();
      do_reset();
      drive(1'b1, P_X1, 1'b0);
      drive(1'b1, P_X1, 1'b0);
      drive(1'b1, P_X1, 1'b0);
      checks++; if (state !== P_S3) begin failures++; $display("FAIL race_entry got=%b exp=%b", state, P_S3); end
      for (int k = 1; k <= 15; k++) drive(1'b0, P_X0, 1'b0);
      checks++; if (state !== P_S3) begin failures++; $display("FAIL race_hold got=%b exp=%b", state, P_S3); end
      // Accepted input on the timeout cycle wins.
      drive(1'b1, P_X2, 1'b0);
      checks++; if (state !== P_S1) begin failures++; $display("FAIL race_state got=%b exp=%b", state, P_S1); end
      checks++; if (timeout_pulse !== 1'b0) begin failures++; $display("FAIL race_pulse got=%b exp=0", timeout_pulse); end
      // Dwell restarted: a full 16 idle cycles are needed again.
      for (int k = 1; k <= 15; k++) begin
         drive(1'b0, P_X0, 1'b0);
         checks++; if (state !== P_S1 || timeout_pulse !== 1'b0) begin
            failures++; $display("FAIL race_restart[%0d] state=%b pulse=%b exp state=%b pulse=0", k, state, timeout_pulse, P_S1);
         end
      end
      drive(1'b0, P_X0, 1'b0);
      checks++; if (state !== P_S0 || timeout_pulse !== 1'b1) begin
         failures++; $display("FAIL race_refire state=%b pulse=%b exp state=%b pulse=1", state, timeout_pulse, P_S0);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, (i % 2 == 0) ? P_X1 : P_X0, 1'b0);
         if (i == 6) begin
            checks++; if (trans_cnt3 !== 3'd7) begin failures++; $display("FAIL sat_at7 got=%0d exp=7", trans_cnt3); end
         end
      end
      checks++; if (trans_cnt3 !== 3'd7) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=7", trans_cnt3); end
      checks++; if (trans_cnt !== 8'd10) begin failures++; $display("FAIL sat_cnt8 got=%0d exp=10", trans_cnt); end
      checks++; if (state3 !== P_S0) begin failures++; $display("FAIL sat_state got=%b exp=%b", state3, P_S0); end
   endtask

   task automatic test_reset_priority();
      do_reset();
      drive(1'b1, 3'b000, 1'b0);
      checks++; if (state !== P_ERR) begin failures++; $display("FAIL rp_err got=%b exp=%b", state, P_ERR); end
      reset = 1'b1;
      drive(1'b1, P_X1, 1'b1);
      reset = 1'b0;
      checks++; if (state !== P_S0) begin failures++; $display("FAIL rp_state got=%b exp=%b", state, P_S0); end
      checks++; if (trans_cnt !== 8'd0) begin failures++; $display("FAIL rp_cnt got=%0d exp=0", trans_cnt); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rp_errflag got=%b exp=0", err); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, P_X1, 1'b0);
         checks++; if (state !== P_S0 || trans_cnt !== 8'd0) begin
            failures++; $display("FAIL rp_hold[%0d] state=%b cnt=%0d exp state=%b cnt=0", i, state, trans_cnt, P_S0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_err();
      test_timeout();
      test_timeout_race();
      test_saturate();
      test_reset_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
